// File: rtl/audio_pkg.sv
// Shared definitions for the audio-path tone detector.
//
// Contents:
//   SAMPLE_W        audio word width delivered by Audio_Controller
//   state_t         detector states (SILENT, ACQUIRE, MEASURE)
//   sample_class_t  polarity class of one sample (NONE, POS, NEG)
//   is_opposite()   true when a sample class is the opposite of the
//                   currently registered polarity (1 = positive)
package audio_pkg;

    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        SILENT,
        ACQUIRE,
        MEASURE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_POS,
        CLS_NEG
    } sample_class_t;

    // A NONE sample is never opposite to anything, so it can never
    // produce an edge.
    function automatic logic is_opposite(sample_class_t cls, logic pol);
        return ((cls == CLS_POS) && !pol) || ((cls == CLS_NEG) && pol);
    endfunction

endpackage

// File: rtl/sample_classifier.sv
// Combinational polarity classifier with a symmetric dead band.
//
// Ports:
//   sample        signed audio sample (SAMPLE_W bits)
//   sample_class  CLS_POS when sample > +THRESH,
//                 CLS_NEG when sample < -THRESH,
//                 CLS_NONE otherwise
module sample_classifier #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int THRESH   = 1000000
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    output audio_pkg::sample_class_t   sample_class
);

    import audio_pkg::*;

    localparam logic signed [SAMPLE_W-1:0] POS_LIMIT = SAMPLE_W'(THRESH);
    localparam logic signed [SAMPLE_W-1:0] NEG_LIMIT = SAMPLE_W'(-THRESH);

    // Both operands are signed, so these are full-width signed compares.
    always_comb begin
        sample_class = CLS_NONE;
        if (sample > POS_LIMIT) begin
            sample_class = CLS_POS;
        end else if (sample < NEG_LIMIT) begin
            sample_class = CLS_NEG;
        end
    end

endmodule

// File: rtl/square_wave_detector.sv
// Receive-side square-wave tone detector for the DE2-115 audio path.
// Pops left-channel samples from Audio_Controller, classifies them with
// hysteresis and times polarity changes in CLOCK_50 cycles.
//
// Ports:
//   CLOCK_50               system clock
//   reset                  synchronous, active-high reset
//   audio_in_available     Audio_Controller input FIFO not empty
//   left_channel_audio_in  signed sample at the FIFO head
//   read_audio_in          pop strobe (combinational)
//   half_period            last measured half-period in CLOCK_50 cycles
//   period_valid           one-cycle pulse when half_period updates
//   locked                 LOCK_COUNT consecutive matching half-periods
//   silent                 no tone present
//   polarity               current registered class (1 = positive)
module square_wave_detector #(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int THRESH     = 1000000,
    parameter int CNT_W      = 24,
    parameter int TIMEOUT    = 5000000,
    parameter int TOL        = 2048,
    parameter int LOCK_COUNT = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       audio_in_available,
    input  logic signed [SAMPLE_W-1:0] left_channel_audio_in,
    output logic                       read_audio_in,
    output logic [CNT_W-1:0]           half_period,
    output logic                       period_valid,
    output logic                       locked,
    output logic                       silent,
    output logic                       polarity
);

    import audio_pkg::*;

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   TIMEOUT_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   TOL_C       = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]   ONE_C       = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_C      = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);

    state_t             state;
    state_t             state_next;
    sample_class_t      sample_class;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   elapsed;
    logic [CNT_W-1:0]   diff;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] match_next;
    logic               have_ref;
    logic               have_ref_next;
    logic [CNT_W-1:0]   half_period_next;
    logic               period_valid_next;
    logic               locked_next;
    logic               silent_next;
    logic               polarity_next;
    logic               valid_class;
    logic               edge_seen;
    logic               timeout_hit;

    // The FIFO is popped whenever it has data; every popped sample is
    // consumed in the same cycle, so no back-pressure is needed.
    assign read_audio_in = audio_in_available & ~reset;

    sample_classifier #(
        .SAMPLE_W (SAMPLE_W),
        .THRESH   (THRESH)
    ) u_classifier (
        .sample       (left_channel_audio_in),
        .sample_class (sample_class)
    );

    assign valid_class = read_audio_in && (sample_class != CLS_NONE);
    assign edge_seen   = read_audio_in && is_opposite(sample_class, polarity);

    // cnt is cleared in the edge cycle itself, so on the following edge it
    // holds one less than the number of cycles between the two edges.
    // elapsed is that true edge-to-edge distance; measurements and the
    // silence timeout are both expressed in it, so a tone reported as
    // N cycles really has edges N cycles apart and silence is declared
    // exactly TIMEOUT cycles after the last edge.
    assign elapsed     = cnt + ONE_C;
    assign timeout_hit = (cnt == TIMEOUT_M1);
    assign diff        = (elapsed >= half_period) ? (elapsed - half_period)
                                                  : (half_period - elapsed);

    // Next-state, counter and lock evaluation. An edge always takes
    // priority over a timeout landing in the same cycle.
    always_comb begin
        state_next        = state;
        cnt_next          = (cnt == TIMEOUT_C) ? cnt : (cnt + ONE_C);
        match_next        = match;
        have_ref_next     = have_ref;
        half_period_next  = half_period;
        period_valid_next = 1'b0;
        locked_next       = locked;
        silent_next       = silent;
        polarity_next     = polarity;

        case (state)
            SILENT: begin
                if (valid_class) begin
                    polarity_next = (sample_class == CLS_POS);
                    cnt_next      = '0;
                    state_next    = ACQUIRE;
                end
            end

            ACQUIRE: begin
                // The tone's start phase is unknown, so this first edge
                // only starts the stopwatch.
                if (edge_seen) begin
                    polarity_next = ~polarity;
                    cnt_next      = '0;
                    silent_next   = 1'b0;
                    have_ref_next = 1'b0;
                    state_next    = MEASURE;
                end else if (timeout_hit) begin
                    state_next       = SILENT;
                    silent_next      = 1'b1;
                    locked_next      = 1'b0;
                    match_next       = '0;
                    half_period_next = '0;
                end
            end

            MEASURE: begin
                if (edge_seen) begin
                    half_period_next  = elapsed;
                    period_valid_next = 1'b1;
                    polarity_next     = ~polarity;
                    cnt_next          = '0;
                    have_ref_next     = 1'b1;
                    // The first measurement has nothing to be compared to.
                    if (!have_ref) begin
                        match_next = MATCH_ONE;
                    end else if (diff <= TOL_C) begin
                        match_next = (match == LOCK_C) ? match
                                                       : (match + MATCH_ONE);
                    end else begin
                        match_next = MATCH_ONE;
                    end
                    locked_next = (match_next == LOCK_C);
                end else if (timeout_hit) begin
                    state_next       = SILENT;
                    silent_next      = 1'b1;
                    locked_next      = 1'b0;
                    match_next       = '0;
                    half_period_next = '0;
                end
            end

            default: begin
                state_next = SILENT;
            end
        endcase
    end

    // State register; reset discards any partial measurement.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= SILENT;
            cnt          <= '0;
            match        <= '0;
            have_ref     <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            silent       <= 1'b1;
            polarity     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            match        <= match_next;
            have_ref     <= have_ref_next;
            half_period  <= half_period_next;
            period_valid <= period_valid_next;
            locked       <= locked_next;
            silent       <= silent_next;
            polarity     <= polarity_next;
        end
    end

endmodule

// File: tb/tb_square_wave_detector.sv
// Directed testbench for square_wave_detector. Timing constants are scaled
// down (100-cycle sample spacing, 10 samples per half) so that a full run
// stays short; TIMEOUT and TOL are overridden to fit that scale.
module tb_square_wave_detector;

    localparam int SAMPLE_W   = 32;
    localparam int THRESH     = 1000000;
    localparam int CNT_W      = 24;
    localparam int TIMEOUT    = 5000;
    localparam int TOL        = 100;
    localparam int LOCK_COUNT = 4;

    localparam int BIG     = 10000000;
    localparam int SMALL   = 500000;
    localparam int SPACING = 100;
    localparam int HALF    = 10 * SPACING;

    logic                       CLOCK_50 = 1'b0;
    logic                       reset;
    logic                       audio_in_available;
    logic signed [SAMPLE_W-1:0] left_channel_audio_in;
    logic                       read_audio_in;
    logic [CNT_W-1:0]           half_period;
    logic                       period_valid;
    logic                       locked;
    logic                       silent;
    logic                       polarity;

    int total     = 0;
    int bad       = 0;
    int pv_pulses = 0;
    int base;

    logic             cap_pv, cap_lk, cap_sl, cap_pol;
    logic [CNT_W-1:0] cap_hp;
    logic             e_pv, e_lk, e_sl, e_pol;
    logic [CNT_W-1:0] e_hp;

    square_wave_detector #(
        .SAMPLE_W   (SAMPLE_W),
        .THRESH     (THRESH),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .CLOCK_50              (CLOCK_50),
        .reset                 (reset),
        .audio_in_available    (audio_in_available),
        .left_channel_audio_in (left_channel_audio_in),
        .read_audio_in         (read_audio_in),
        .half_period           (half_period),
        .period_valid          (period_valid),
        .locked                (locked),
        .silent                (silent),
        .polarity              (polarity)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (period_valid === 1'b1) pv_pulses++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Presents one sample for one cycle and captures the outputs that
    // result from accepting it.
    task automatic applyStimulus(input int value);
        audio_in_available    = 1'b1;
        left_channel_audio_in = value;
        @(negedge CLOCK_50);
        audio_in_available    = 1'b0;
        left_channel_audio_in = '0;
        cap_pv  = period_valid;
        cap_lk  = locked;
        cap_sl  = silent;
        cap_pol = polarity;
        cap_hp  = half_period;
    endtask

    // One half of a tone: 10 samples of one sign at the given spacing plus
    // optional extra idle cycles. The e_* values are from the first sample.
    task automatic send_half(input bit positive, input int spacing, input int extra);
        applyStimulus(positive ? BIG : -BIG);
        e_pv = cap_pv; e_lk = cap_lk; e_sl = cap_sl; e_pol = cap_pol; e_hp = cap_hp;
        idle(spacing - 1);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(positive ? BIG : -BIG);
            idle(spacing - 1);
        end
        idle(extra);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        audio_in_available = 1'b0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        audio_in_available = 1'b1;
        left_channel_audio_in = BIG;
        idle(5);
        total++; if (read_audio_in !== 1'b0) begin bad++; $display("[TB] FAIL reset_read: got %0b want 0", read_audio_in); end
        total++; if (silent !== 1'b1) begin bad++; $display("[TB] FAIL reset_silent: got %0b want 1", silent); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
        total++; if (half_period !== '0) begin bad++; $display("[TB] FAIL reset_hp: got %0d want 0", half_period); end
        total++; if (period_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pv: got %0b want 0", period_valid); end
        total++; if (polarity !== 1'b0) begin bad++; $display("[TB] FAIL reset_pol: got %0b want 0", polarity); end
        reset = 1'b0;
        audio_in_available = 1'b0;
        left_channel_audio_in = '0;
        idle(1);
        total++; if (silent !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_silent: got %0b want 1", silent); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_locked: got %0b want 0", locked); end
        total++; if (half_period !== '0) begin bad++; $display("[TB] FAIL post_reset_hp: got %0d want 0", half_period); end
        total++; if (polarity !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_pol: got %0b want 0", polarity); end
        audio_in_available = 1'b1;
        #1;
        total++; if (read_audio_in !== 1'b1) begin bad++; $display("[TB] FAIL handshake_read: got %0b want 1", read_audio_in); end
        @(negedge CLOCK_50);
        audio_in_available = 1'b0;
        total++; if (polarity !== 1'b0) begin bad++; $display("[TB] FAIL zero_sample_pol: got %0b want 0", polarity); end
    endtask

    task automatic test_lock();
        send_half(1, SPACING, 0);
        total++; if (e_pol !== 1'b1) begin bad++; $display("[TB] FAIL lock_a_pol: got %0b want 1", e_pol); end
        total++; if (e_sl !== 1'b1) begin bad++; $display("[TB] FAIL lock_a_silent: got %0b want 1", e_sl); end
        send_half(0, SPACING, 0);
        total++; if (e_sl !== 1'b0) begin bad++; $display("[TB] FAIL lock_b_silent: got %0b want 0", e_sl); end
        total++; if (e_pv !== 1'b0) begin bad++; $display("[TB] FAIL lock_b_pv: got %0b want 0", e_pv); end
        send_half(1, SPACING, 0);
        total++; if (e_pv !== 1'b1) begin bad++; $display("[TB] FAIL lock_c_pv: got %0b want 1", e_pv); end
        total++; if (e_hp !== CNT_W'(HALF)) begin bad++; $display("[TB] FAIL lock_c_hp: got %0d want %0d", e_hp, HALF); end
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL lock_c_locked: got %0b want 0", e_lk); end
        send_half(0, SPACING, 0);
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL lock_d_locked: got %0b want 0", e_lk); end
        send_half(1, SPACING, 0);
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL lock_e_locked: got %0b want 0", e_lk); end
        applyStimulus(-BIG);
        total++; if (cap_lk !== 1'b1) begin bad++; $display("[TB] FAIL lock_f_locked: got %0b want 1", cap_lk); end
        total++; if (cap_hp !== CNT_W'(HALF)) begin bad++; $display("[TB] FAIL lock_f_hp: got %0d want %0d", cap_hp, HALF); end
        #1;
        total++; if (pv_pulses !== 4) begin bad++; $display("[TB] FAIL lock_pulse_count: got %0d want 4", pv_pulses); end
    endtask

    task automatic test_silence();
        base = pv_pulses;
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            if (c % SPACING == 0) begin
                audio_in_available    = 1'b1;
                left_channel_audio_in = ((c / SPACING) % 2 == 1) ? SMALL : -SMALL;
            end
            @(negedge CLOCK_50);
            audio_in_available = 1'b0;
            if (c == 1) begin
                total++; if (period_valid !== 1'b0) begin bad++; $display("[TB] FAIL pulse_width: got %0b want 0", period_valid); end
            end
            if (c == TIMEOUT - 1) begin
                total++; if (silent !== 1'b0) begin bad++; $display("[TB] FAIL silence_early: got %0b want 0", silent); end
                total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL silence_early_locked: got %0b want 1", locked); end
            end
            if (c == TIMEOUT) begin
                total++; if (silent !== 1'b1) begin bad++; $display("[TB] FAIL silence_at_timeout: got %0b want 1", silent); end
                total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL silence_locked: got %0b want 0", locked); end
                total++; if (half_period !== '0) begin bad++; $display("[TB] FAIL silence_hp: got %0d want 0", half_period); end
            end
        end
        #1;
        total++; if (pv_pulses !== base) begin bad++; $display("[TB] FAIL silence_no_pv: got %0d want %0d", pv_pulses, base); end
    endtask

    task automatic test_zero_samples();
        applyStimulus(BIG);
        total++; if (cap_pol !== 1'b1) begin bad++; $display("[TB] FAIL zero_first_pol: got %0b want 1", cap_pol); end
        idle(SPACING - 1);
        applyStimulus(0);
        idle(SPACING - 1);
        applyStimulus(0);
        total++; if (cap_pol !== 1'b1) begin bad++; $display("[TB] FAIL zero_hold_pol: got %0b want 1", cap_pol); end
        idle(SPACING - 1);
        applyStimulus(BIG);
        total++; if (cap_sl !== 1'b1) begin bad++; $display("[TB] FAIL zero_same_sign_silent: got %0b want 1", cap_sl); end
        idle(SPACING - 1);
        applyStimulus(-BIG);
        total++; if (cap_sl !== 1'b0) begin bad++; $display("[TB] FAIL zero_edge_silent: got %0b want 0", cap_sl); end
        total++; if (cap_pol !== 1'b0) begin bad++; $display("[TB] FAIL zero_edge_pol: got %0b want 0", cap_pol); end
        total++; if (cap_pv !== 1'b0) begin bad++; $display("[TB] FAIL zero_edge_pv: got %0b want 0", cap_pv); end
    endtask

    task automatic test_tolerance();
        do_reset();
        send_half(1, SPACING, 0);
        send_half(0, SPACING, 0);
        send_half(1, SPACING, 0);
        send_half(0, SPACING, 0);
        send_half(1, SPACING, 0);
        send_half(0, SPACING, TOL);
        total++; if (e_lk !== 1'b1) begin bad++; $display("[TB] FAIL tol_locked: got %0b want 1", e_lk); end
        send_half(1, SPACING, 2 * TOL + 1);
        total++; if (e_hp !== CNT_W'(HALF + TOL)) begin bad++; $display("[TB] FAIL tol_edge_hp: got %0d want %0d", e_hp, HALF + TOL); end
        total++; if (e_lk !== 1'b1) begin bad++; $display("[TB] FAIL tol_edge_locked: got %0b want 1", e_lk); end
        send_half(0, SPACING, 0);
        total++; if (e_hp !== CNT_W'(HALF + 2 * TOL + 1)) begin bad++; $display("[TB] FAIL tol_over_hp: got %0d want %0d", e_hp, HALF + 2 * TOL + 1); end
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL tol_over_locked: got %0b want 0", e_lk); end
    endtask

    task automatic test_period_change();
        do_reset();
        send_half(1, SPACING, 0);
        send_half(0, SPACING, 0);
        send_half(1, SPACING, 0);
        send_half(0, SPACING, 0);
        send_half(1, SPACING, 0);
        send_half(0, SPACING, 0);
        total++; if (e_lk !== 1'b1) begin bad++; $display("[TB] FAIL change_lock_1000: got %0b want 1", e_lk); end
        send_half(1, 2 * SPACING, 0);
        total++; if (e_lk !== 1'b1) begin bad++; $display("[TB] FAIL change_still_locked: got %0b want 1", e_lk); end
        send_half(0, 2 * SPACING, 0);
        total++; if (e_hp !== CNT_W'(2 * HALF)) begin bad++; $display("[TB] FAIL change_hp: got %0d want %0d", e_hp, 2 * HALF); end
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL change_unlock: got %0b want 0", e_lk); end
        send_half(1, 2 * SPACING, 0);
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL change_second: got %0b want 0", e_lk); end
        send_half(0, 2 * SPACING, 0);
        total++; if (e_lk !== 1'b0) begin bad++; $display("[TB] FAIL change_third: got %0b want 0", e_lk); end
        applyStimulus(BIG);
        total++; if (cap_lk !== 1'b1) begin bad++; $display("[TB] FAIL change_relock: got %0b want 1", cap_lk); end
        total++; if (cap_hp !== CNT_W'(2 * HALF)) begin bad++; $display("[TB] FAIL change_relock_hp: got %0d want %0d", cap_hp, 2 * HALF); end
    endtask

    task automatic test_reset_mid();
        idle(300);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        total++; if (silent !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_silent: got %0b want 1", silent); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_locked: got %0b want 0", locked); end
        total++; if (half_period !== '0) begin bad++; $display("[TB] FAIL mid_reset_hp: got %0d want 0", half_period); end
        total++; if (period_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_pv: got %0b want 0", period_valid); end
        idle(1);
        total++; if (period_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_pv_hold: got %0b want 0", period_valid); end
        total++; if (silent !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_silent_hold: got %0b want 1", silent); end
        applyStimulus(-BIG);
        idle(HALF - 1);
        applyStimulus(BIG);
        total++; if (cap_pv !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_no_partial: got %0b want 0", cap_pv); end
        total++; if (cap_sl !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_reacquire: got %0b want 0", cap_sl); end
    endtask

    initial begin
        reset = 1'b1;
        audio_in_available = 1'b0;
        left_channel_audio_in = '0;
        @(negedge CLOCK_50);
        test_reset();
        test_lock();
        test_silence();
        test_zero_samples();
        test_tolerance();
        test_period_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
